instr_decode_pipe: RTL and testbench
====================================

Name: instr_decode_pipe

Overview:
Registered, parametrised successor to the combinational RV32I decoder. It sits between fetch and execute and accepts one instruction per cycle over a valid/ready handshake. It decodes all RV32I formats, including lui and auipc, and reads the register file. It forwards a same-cycle writeback result, computes PC-relative targets, flags illegal opcodes, and holds its output register stable under back-pressure or clears it on flush.

Parameters:
XLEN, 32, datapath width of pc, operands, immediates and targets; immediates sign-extend to XLEN.
BYPASS, 1, 1 forwards wb_data onto matching register reads; 0 reads rdata1/rdata2 unmodified.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  fetch presents an instruction
in_ready  out  1  stage can accept this cycle
in_instr  in  32  instruction word
in_pc  in  XLEN  address of in_instr
flush  in  1  squash the held and the incoming instruction
raddr1  out  5  regfile read address, combinational from in_instr[19:15]
raddr2  out  5  regfile read address, combinational from in_instr[24:20]
rdata1  in  XLEN  regfile read data for raddr1 (asynchronous read)
rdata2  in  XLEN  regfile read data for raddr2 (asynchronous read)
wb_en  in  1  writeback strobe
wb_addr  in  5  writeback register
wb_data  in  XLEN  writeback value
out_valid  out  1  decoded instruction held
out_ready  in  1  execute consumes this cycle
is_store, is_load, is_branch, is_jump, is_reg, is_alu, is_lui, is_auipc  out  1 each  class flags
illegal  out  1  opcode not in RV32I base set
operand_a  out  XLEN  first operand
operand_b  out  XLEN  second operand
imm  out  XLEN  sign-extended immediate
branch_dest  out  XLEN  control-transfer target
dest  out  5  rd; 0 for branch and store
func3  out  3  instr[14:12]
func7  out  1  instr[30]
out_pc  out  XLEN  pc of the held instruction

Behaviour:
- Reset (sync, active-high) zeroes every registered output: out_valid, all flags, illegal, operands, imm, branch_dest, dest, func3, func7, out_pc.
- in_ready = !out_valid | out_ready. This is combinational and is 1 during reset.
- A capture (in_valid & in_ready & !flush) loads the output register next edge and sets out_valid=1. Latency is 1 cycle.
- Consume without capture clears out_valid. Capture and consume in the same cycle loads the new instruction back-to-back.
- When out_valid & !out_ready, all outputs hold bit-stable.
- flush has priority: out_valid=0 next edge and the incoming instruction is dropped. Data fields may keep stale values; only out_valid is cleared.
- Forwarding (BYPASS=1): if wb_en & wb_addr==rsN & rsN!=0, use wb_data instead of rdataN. A read of x0 always yields 0.
- Immediates follow the I/S/B/U/J formats, sign-extended to XLEN. B and J immediates have bit0=0.
- Operands and targets per class:
  - lui: is_lui; operand_a=0, operand_b=imm.
  - auipc: is_auipc; operand_a=pc, operand_b=imm.
  - jal: is_jump; operand_a=pc, operand_b=4, branch_dest=pc+imm.
  - jalr: is_jump & is_reg; operand_a=pc, operand_b=4, branch_dest=(rs1+imm)&~1.
  - branch: is_branch; operand_a=rs1, operand_b=rs2, branch_dest=pc+imm.
  - load: is_load; operand_a=rs1, operand_b=imm.
  - store: is_store; operand_a=rs1, operand_b=rs2, imm=S-imm.
  - op-imm: is_alu; operand_a=rs1, operand_b=imm.
  - op: is_alu & is_reg; operand_a=rs1, operand_b=rs2.
- For srai/srli, func7 carries instr[30] and imm[4:0] is the shamt.
- Arithmetic is modulo 2^XLEN, so targets wrap silently.
- An unknown opcode, or any instr[1:0]!=2'b11, sets illegal=1 with all class flags 0 and dest=0. It still handshakes normally.

Decomposition:
- Shared package: opcode localparams (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_OP) and immediate-format enum (FMT_I/S/B/U/J).
- One sub-module, imm_gen: a combinational (instr, fmt) -> XLEN immediate.

Test Plan:
- Reset held 2 cycles -> out_valid=0, all outputs 0, in_ready=1.
- jal 0x7D0001EF at pc=0x100 -> next cycle: out_valid=1, is_jump=1, dest=3, imm=2000, branch_dest=0x8D0, operand_a=0x100, operand_b=4.
- beq rs1=x15 (9876), rs2=x14 (4567), imm=2000, pc=0, with wb_en=1, wb_addr=14, wb_data=777 in the capture cycle -> operand_a=9876, operand_b=777, branch_dest=2000, func3=0. With BYPASS=0 the same stimulus gives operand_b=4567.
- addi then add with out_ready=0 for 3 cycles -> addi outputs stable, in_ready=0. When out_ready rises, add is captured the next cycle with no loss or duplication.
- flush asserted together with in_valid while an instruction is held -> next cycle out_valid=0 and the incoming instruction never appears.
- Word 0x00000000 -> illegal=1, all class flags 0; lui x5,0x12345 -> is_lui=1, operand_b=0x12345000, dest=5.

Source files
------------

// File: rtl/instr_decode_pipe_pkg.sv
// Shared RV32I decode definitions: base opcodes, immediate formats and the
// control-flag bundle carried in the decode output register.
package instr_decode_pipe_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } imm_fmt_e;

    typedef struct packed {
        logic is_store;
        logic is_load;
        logic is_branch;
        logic is_jump;
        logic is_reg;
        logic is_alu;
        logic is_lui;
        logic is_auipc;
        logic illegal;
    } ctrl_t;

endpackage

// File: rtl/instr_decode_pipe_imm_gen.sv
// Combinational RV32I immediate extraction for the I/S/B/U/J formats,
// sign-extended to the datapath width.
module instr_decode_pipe_imm_gen
    import instr_decode_pipe_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     instr,
    input  imm_fmt_e        fmt,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        unique case (fmt)
            FMT_S:   imm32 = {{21{instr[31]}}, instr[30:25], instr[11:7]};
            FMT_B:   imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   imm32 = {instr[31:12], 12'b0};
            FMT_J:   imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = {{21{instr[31]}}, instr[30:20]};
        endcase
    end

    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/instr_decode_pipe.sv
// Registered RV32I decode stage between fetch and execute: regfile read with
// writeback forwarding, operand/target formation and a valid/ready output register.
module instr_decode_pipe
    import instr_decode_pipe_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter bit          BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic [4:0]      raddr1,
    output logic [4:0]      raddr2,
    input  logic [XLEN-1:0] rdata1,
    input  logic [XLEN-1:0] rdata2,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            is_store,
    output logic            is_load,
    output logic            is_branch,
    output logic            is_jump,
    output logic            is_reg,
    output logic            is_alu,
    output logic            is_lui,
    output logic            is_auipc,
    output logic            illegal,
    output logic [XLEN-1:0] operand_a,
    output logic [XLEN-1:0] operand_b,
    output logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] branch_dest,
    output logic [4:0]      dest,
    output logic [2:0]      func3,
    output logic            func7,
    output logic [XLEN-1:0] out_pc
);

    typedef struct packed {
        ctrl_t           ctrl;
        logic [XLEN-1:0] op_a;
        logic [XLEN-1:0] op_b;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] branch_dest;
        logic [XLEN-1:0] pc;
        logic [4:0]      dest;
        logic [2:0]      func3;
        logic            func7;
    } dec_t;

    logic [6:0]      opcode;
    imm_fmt_e        fmt;
    logic [XLEN-1:0] imm_val;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            capture;
    dec_t            dec;
    dec_t            out_d, out_q;
    logic            out_valid_d, out_valid_q;

    // x0 reads as zero even if the regfile or a writeback says otherwise.
    function automatic logic [XLEN-1:0] read_src(input logic [4:0]      addr,
                                                 input logic [XLEN-1:0] rdata);
        if (addr == 5'd0) return '0;
        if (BYPASS && wb_en && (wb_addr == addr)) return wb_data;
        return rdata;
    endfunction

    assign opcode = in_instr[6:0];
    assign raddr1 = in_instr[19:15];
    assign raddr2 = in_instr[24:20];
    assign src1   = read_src(raddr1, rdata1);
    assign src2   = read_src(raddr2, rdata2);

    always_comb begin
        unique case (opcode)
            OP_LUI, OP_AUIPC: fmt = FMT_U;
            OP_JAL:           fmt = FMT_J;
            OP_BRANCH:        fmt = FMT_B;
            OP_STORE:         fmt = FMT_S;
            default:          fmt = FMT_I;
        endcase
    end

    instr_decode_pipe_imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .instr (in_instr),
        .fmt   (fmt),
        .imm   (imm_val)
    );

    always_comb begin
        dec       = '0;
        dec.pc    = in_pc;
        dec.dest  = in_instr[11:7];
        dec.func3 = in_instr[14:12];
        dec.func7 = in_instr[30];
        dec.imm   = imm_val;
        unique case (opcode)
            OP_LUI: begin
                dec.ctrl.is_lui = 1'b1;
                dec.op_b        = imm_val;
            end
            OP_AUIPC: begin
                dec.ctrl.is_auipc = 1'b1;
                dec.op_a          = in_pc;
                dec.op_b          = imm_val;
            end
            OP_JAL: begin
                dec.ctrl.is_jump = 1'b1;
                dec.op_a         = in_pc;
                dec.op_b         = XLEN'(4);
                dec.branch_dest  = in_pc + imm_val;
            end
            OP_JALR: begin
                dec.ctrl.is_jump = 1'b1;
                dec.ctrl.is_reg  = 1'b1;
                dec.op_a         = in_pc;
                dec.op_b         = XLEN'(4);
                dec.branch_dest  = (src1 + imm_val) & ~XLEN'(1);
            end
            OP_BRANCH: begin
                dec.ctrl.is_branch = 1'b1;
                dec.op_a           = src1;
                dec.op_b           = src2;
                dec.branch_dest    = in_pc + imm_val;
                dec.dest           = 5'd0;
            end
            OP_LOAD: begin
                dec.ctrl.is_load = 1'b1;
                dec.op_a         = src1;
                dec.op_b         = imm_val;
            end
            OP_STORE: begin
                dec.ctrl.is_store = 1'b1;
                dec.op_a          = src1;
                dec.op_b          = src2;
                dec.dest          = 5'd0;
            end
            OP_IMM: begin
                dec.ctrl.is_alu = 1'b1;
                dec.op_a        = src1;
                dec.op_b        = imm_val;
            end
            OP_OP: begin
                dec.ctrl.is_alu = 1'b1;
                dec.ctrl.is_reg = 1'b1;
                dec.op_a        = src1;
                dec.op_b        = src2;
                dec.imm         = '0;
            end
            // Also catches instr[1:0] != 2'b11, since every base opcode ends in 11.
            default: begin
                dec.ctrl.illegal = 1'b1;
                dec.dest         = 5'd0;
                dec.imm          = '0;
            end
        endcase
    end

    assign in_ready = !out_valid_q || out_ready;
    assign capture  = in_valid && in_ready && !flush;

    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (capture) begin
            out_valid_d = 1'b1;
            out_d       = dec;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign is_store    = out_q.ctrl.is_store;
    assign is_load     = out_q.ctrl.is_load;
    assign is_branch   = out_q.ctrl.is_branch;
    assign is_jump     = out_q.ctrl.is_jump;
    assign is_reg      = out_q.ctrl.is_reg;
    assign is_alu      = out_q.ctrl.is_alu;
    assign is_lui      = out_q.ctrl.is_lui;
    assign is_auipc    = out_q.ctrl.is_auipc;
    assign illegal     = out_q.ctrl.illegal;
    assign operand_a   = out_q.op_a;
    assign operand_b   = out_q.op_b;
    assign imm         = out_q.imm;
    assign branch_dest = out_q.branch_dest;
    assign dest        = out_q.dest;
    assign func3       = out_q.func3;
    assign func7       = out_q.func7;
    assign out_pc      = out_q.pc;

endmodule

// File: tb/tb_instr_decode_pipe.sv
// Scoreboard bench for instr_decode_pipe: directed RV32I words with hand-computed
// expected decode results, checked by a monitor whenever execute consumes an output.
module tb_instr_decode_pipe;

    localparam logic [8:0] F_STORE  = 9'h100;
    localparam logic [8:0] F_LOAD   = 9'h080;
    localparam logic [8:0] F_BRANCH = 9'h040;
    localparam logic [8:0] F_JUMP   = 9'h020;
    localparam logic [8:0] F_REG    = 9'h010;
    localparam logic [8:0] F_ALU    = 9'h008;
    localparam logic [8:0] F_LUI    = 9'h004;
    localparam logic [8:0] F_AUIPC  = 9'h002;
    localparam logic [8:0] F_ILL    = 9'h001;

    logic        clk = 1'b0;
    logic        reset, in_valid, flush, wb_en, out_ready;
    logic [31:0] in_instr, in_pc, wb_data, rdata1, rdata2;
    logic [4:0]  wb_addr, raddr1, raddr2;
    logic        in_ready, out_valid;
    logic        is_store, is_load, is_branch, is_jump, is_reg, is_alu, is_lui, is_auipc, illegal;
    logic [31:0] operand_a, operand_b, imm, branch_dest, out_pc;
    logic [4:0]  dest;
    logic [2:0]  func3;
    logic        func7;

    logic        nb_in_ready, nb_out_valid;
    logic        nb_is_store, nb_is_load, nb_is_branch, nb_is_jump, nb_is_reg, nb_is_alu;
    logic        nb_is_lui, nb_is_auipc, nb_illegal, nb_func7;
    logic [31:0] nb_operand_a, nb_operand_b, nb_imm, nb_branch_dest, nb_out_pc;
    logic [4:0]  nb_dest, nb_raddr1, nb_raddr2;
    logic [2:0]  nb_func3;

    logic [31:0] regs [32];

    typedef struct {
        logic [8:0]  flags;
        logic [31:0] a, b, imm, bd, pc;
        logic [4:0]  dest;
        logic [2:0]  f3;
        logic        f7;
        logic [3:0]  care;  // {bd, imm, b, a}
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    assign rdata1 = regs[raddr1];
    assign rdata2 = regs[raddr2];

    instr_decode_pipe #(.XLEN(32), .BYPASS(1'b1)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .is_store(is_store), .is_load(is_load), .is_branch(is_branch), .is_jump(is_jump),
        .is_reg(is_reg), .is_alu(is_alu), .is_lui(is_lui), .is_auipc(is_auipc),
        .illegal(illegal), .operand_a(operand_a), .operand_b(operand_b), .imm(imm),
        .branch_dest(branch_dest), .dest(dest), .func3(func3), .func7(func7),
        .out_pc(out_pc)
    );

    // Same stimulus without forwarding; regfile shared through the same addresses.
    instr_decode_pipe #(.XLEN(32), .BYPASS(1'b0)) u_dut_nb (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(nb_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .raddr1(nb_raddr1), .raddr2(nb_raddr2), .rdata1(rdata1), .rdata2(rdata2),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(nb_out_valid), .out_ready(out_ready),
        .is_store(nb_is_store), .is_load(nb_is_load), .is_branch(nb_is_branch),
        .is_jump(nb_is_jump), .is_reg(nb_is_reg), .is_alu(nb_is_alu), .is_lui(nb_is_lui),
        .is_auipc(nb_is_auipc), .illegal(nb_illegal), .operand_a(nb_operand_a),
        .operand_b(nb_operand_b), .imm(nb_imm), .branch_dest(nb_branch_dest),
        .dest(nb_dest), .func3(nb_func3), .func7(nb_func7), .out_pc(nb_out_pc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [8:0] flags, input logic [31:0] a, b, im, bd,
                                input logic [4:0] d, input logic [2:0] f3, input logic f7,
                                input logic [31:0] pc, input logic [3:0] care);
        exp_t e;
        e.flags = flags; e.a = a; e.b = b; e.imm = im; e.bd = bd;
        e.dest = d; e.f3 = f3; e.f7 = f7; e.pc = pc; e.care = care;
        return e;
    endfunction

    task automatic issue(input logic [31:0] instr, input logic [31:0] pc, input exp_t e,
                         input bit push);
        int budget = 50;
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        #1;
        while (!in_ready && budget > 0) begin
            @(negedge clk);
            #1;
            budget--;
        end
        chk("in_ready_wait", 32'(in_ready), 32'd1);
        @(posedge clk);
        if (push) sb.push_back(e);
        #1;
        in_valid = 1'b0;
        wb_en    = 1'b0;
    endtask

    // Monitor: compare the held instruction in the cycle execute consumes it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got pc %h, want no output", out_pc);
                end else begin
                    e = sb.pop_front();
                    chk("flags", 32'({is_store, is_load, is_branch, is_jump, is_reg, is_alu,
                                      is_lui, is_auipc, illegal}), 32'(e.flags));
                    chk("dest", 32'(dest), 32'(e.dest));
                    chk("func3", 32'(func3), 32'(e.f3));
                    chk("func7", 32'(func7), 32'(e.f7));
                    chk("out_pc", out_pc, e.pc);
                    if (e.care[0]) chk("operand_a", operand_a, e.a);
                    if (e.care[1]) chk("operand_b", operand_b, e.b);
                    if (e.care[2]) chk("imm", imm, e.imm);
                    if (e.care[3]) chk("branch_dest", branch_dest, e.bd);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, want finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'h1000 + 32'(i);
        regs[0]  = 32'hDEAD;
        regs[2]  = 32'd100;
        regs[3]  = 32'd300;
        regs[14] = 32'd4567;
        regs[15] = 32'd9876;
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
        in_instr = '0; in_pc = '0; wb_addr = '0; wb_data = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_flags", 32'({is_store, is_load, is_branch, is_jump, is_reg, is_alu, is_lui,
                                is_auipc, illegal}), 32'd0);
        chk("reset_operand_a", operand_a, 32'd0);
        chk("reset_operand_b", operand_b, 32'd0);
        chk("reset_imm", imm, 32'd0);
        chk("reset_branch_dest", branch_dest, 32'd0);
        chk("reset_fields", 32'({dest, func3, func7}), 32'd0);
        chk("reset_out_pc", out_pc, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // jal x3, 2000
        issue(32'h7D0001EF, 32'h100,
              mk(F_JUMP, 32'h100, 32'd4, 32'd2000, 32'h8D0, 5'd3, 3'd0, 1'b1, 32'h100, 4'hF), 1);
        // beq x15, x14, 2000 with x14 being written back this cycle
        wb_en = 1'b1; wb_addr = 5'd14; wb_data = 32'd777;
        issue(32'h7CE78863, 32'h0,
              mk(F_BRANCH, 32'd9876, 32'd777, 32'd2000, 32'd2000, 5'd0, 3'd0, 1'b1, 32'h0, 4'hF),
              1);
        chk("nobypass_out_valid", 32'(nb_out_valid), 32'd1);
        chk("nobypass_operand_b", nb_operand_b, 32'd4567);

        // addi x1, x2, -5 held for several cycles, then add x4, x2, x3 behind it
        issue(32'hFFB10093, 32'h10,
              mk(F_ALU, 32'd100, 32'hFFFFFFFB, 32'hFFFFFFFB, 32'h0, 5'd1, 3'd0, 1'b1, 32'h10,
                 4'h7), 1);
        out_ready = 1'b0;
        fork
            issue(32'h00310233, 32'h14,
                  mk(F_ALU | F_REG, 32'd100, 32'd300, 32'h0, 32'h0, 5'd4, 3'd0, 1'b0, 32'h14,
                     4'h3), 1);
            begin
                repeat (3) begin
                    @(negedge clk);
                    #1;
                    chk("stall_in_ready", 32'(in_ready), 32'd0);
                    chk("stall_out_valid", 32'(out_valid), 32'd1);
                    chk("stall_operand_b", operand_b, 32'hFFFFFFFB);
                    chk("stall_out_pc", out_pc, 32'h10);
                end
                @(negedge clk);
                out_ready = 1'b1;
            end
        join

        // lui x5, 0x12345
        issue(32'h123452B7, 32'h18,
              mk(F_LUI, 32'h0, 32'h12345000, 32'h12345000, 32'h0, 5'd5, 3'd5, 1'b0, 32'h18,
                 4'h7), 1);
        // Hold an instruction, then flush it together with an incoming one.
        issue(32'h00310233, 32'h300, mk(9'h0, 0, 0, 0, 0, 5'd0, 3'd0, 1'b0, 0, 4'h0), 0);
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_instr = 32'h7D0001EF; in_pc = 32'h500; flush = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;

        issue(32'h00000000, 32'h1C, mk(F_ILL, 0, 0, 0, 0, 5'd0, 3'd0, 1'b0, 32'h1C, 4'h0), 1);
        // jalr x1, 5(x2): target LSB cleared
        issue(32'h005100E7, 32'h40,
              mk(F_JUMP | F_REG, 32'h40, 32'd4, 32'd5, 32'h68, 5'd1, 3'd0, 1'b0, 32'h40, 4'hF),
              1);
        // sw x14, -4(x15)
        issue(32'hFEE7AE23, 32'h44,
              mk(F_STORE, 32'd9876, 32'd4567, 32'hFFFFFFFC, 0, 5'd0, 3'd2, 1'b1, 32'h44, 4'h7),
              1);
        // srai x6, x15, 3
        issue(32'h4037D313, 32'h48,
              mk(F_ALU, 32'd9876, 32'h403, 32'h403, 0, 5'd6, 3'd5, 1'b1, 32'h48, 4'h7), 1);
        // jal x0, +32 from near the top of the address space: target wraps
        issue(32'h0200006F, 32'hFFFFFFF0,
              mk(F_JUMP, 32'hFFFFFFF0, 32'd4, 32'd32, 32'h10, 5'd0, 3'd0, 1'b0, 32'hFFFFFFF0,
                 4'hF), 1);
        // auipc x7, 0x80000
        issue(32'h80000397, 32'h200,
              mk(F_AUIPC, 32'h200, 32'h80000000, 32'h80000000, 0, 5'd7, 3'd0, 1'b0, 32'h200,
                 4'h7), 1);
        // add x8, x0, x0 with a writeback aimed at x0
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'd55;
        issue(32'h00000433, 32'h204,
              mk(F_ALU | F_REG, 32'h0, 32'h0, 0, 0, 5'd8, 3'd0, 1'b0, 32'h204, 4'h3), 1);
        // low opcode bits not 2'b11
        issue(32'h00000012, 32'h208, mk(F_ILL, 0, 0, 0, 0, 5'd0, 3'd0, 1'b0, 32'h208, 4'h0), 1);
        // lw x9, 8(x14)
        issue(32'h00872483, 32'h20C,
              mk(F_LOAD, 32'd4567, 32'd8, 32'd8, 0, 5'd9, 3'd2, 1'b0, 32'h20C, 4'h7), 1);

        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        chk("idle_out_valid", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
